// File: rtl/vlc_in_sched_if.sv
// Requester-side handshake bundle for vlc_in_sched: N_REQ parallel words,
// their valid flags, and the one-hot acceptance strobe.
interface vlc_in_sched_if #(
    parameter int N_REQ  = 4,
    parameter int WORD_W = 8
);
    logic [N_REQ-1:0]        req_valid;
    logic [N_REQ*WORD_W-1:0] req_data;
    logic [N_REQ-1:0]        req_ready;

    modport master (output req_valid, output req_data, input req_ready);
    modport slave  (input req_valid, input req_data, output req_ready);
endinterface

// File: rtl/vlc_in_sched.sv
// Round-robin scheduler that grants one requester at a time and serializes its
// word MSB-first onto the VLC core input, with a fixed idle gap between frames.
module vlc_in_sched #(
    parameter int N_REQ  = 4,
    parameter int WORD_W = 8,
    parameter int GAP    = 2,
    parameter int CNT_W  = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_enable,
    vlc_in_sched_if.slave            req_if,
    output logic                     o_data_in,
    output logic                     o_din_valid,
    output logic                     o_busy,
    output logic [$clog2(N_REQ)-1:0] o_grant_id,
    output logic [CNT_W-1:0]         o_frame_cnt
);
    localparam int ID_W  = $clog2(N_REQ);
    localparam int BIT_W = $clog2(WORD_W);
    localparam int GAP_W = (GAP > 1) ? $clog2(GAP) : 1;

    typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_GAP} state_t;

    state_t            r_state;
    state_t            w_next_state;
    logic [WORD_W-2:0] r_shift;
    logic [BIT_W-1:0]  r_bit_cnt;
    logic [GAP_W-1:0]  r_gap_cnt;
    logic [ID_W-1:0]   r_rr_ptr;
    logic [ID_W-1:0]   r_grant_id;
    logic [CNT_W-1:0]  r_frame_cnt;
    logic              r_data_in;
    logic              r_din_valid;

    logic              w_grant;
    logic [ID_W-1:0]   w_grant_idx;
    logic [ID_W-1:0]   w_next_ptr;
    logic [WORD_W-1:0] w_word;
    logic              w_last_bit;
    logic              w_gap_done;

    assign w_last_bit = (r_bit_cnt == BIT_W'(WORD_W - 1));
    assign w_gap_done = (r_gap_cnt == GAP_W'(GAP - 1));
    assign w_word     = req_if.req_data[w_grant_idx*WORD_W +: WORD_W];

    // Round-robin search from r_rr_ptr plus next-state decode.
    always_comb begin : fsm_comb
        int idx;
        // NOTE: every combinational output is defaulted first so no path leaves it unassigned (no latch).
        w_grant          = 1'b0;
        w_grant_idx      = r_rr_ptr;
        w_next_ptr       = r_rr_ptr;
        w_next_state     = r_state;
        req_if.req_ready = '0;
        idx              = 0;

        if (r_state == ST_IDLE && i_enable) begin
            for (int k = 0; k < N_REQ; k++) begin
                idx = int'(r_rr_ptr) + k;
                if (idx >= N_REQ) idx = idx - N_REQ;
                if (!w_grant && req_if.req_valid[idx]) begin
                    w_grant     = 1'b1;
                    w_grant_idx = ID_W'(idx);
                end
            end
        end

        if (w_grant) begin
            req_if.req_ready[w_grant_idx] = 1'b1;
            w_next_ptr = (w_grant_idx == ID_W'(N_REQ - 1)) ? '0 : w_grant_idx + ID_W'(1);
        end

        case (r_state)
            ST_IDLE:  if (w_grant) w_next_state = ST_SHIFT;
            ST_SHIFT: if (w_last_bit) w_next_state = (GAP == 0) ? ST_IDLE : ST_GAP;
            ST_GAP:   if (w_gap_done) w_next_state = ST_IDLE;
            default:  w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_next_state;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_shift     <= '0;
            r_bit_cnt   <= '0;
            r_gap_cnt   <= '0;
            r_rr_ptr    <= '0;
            r_grant_id  <= '0;
            r_frame_cnt <= '0;
            r_data_in   <= 1'b0;
            r_din_valid <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_grant) begin
                        r_data_in   <= w_word[WORD_W-1];
                        r_shift     <= w_word[WORD_W-2:0];
                        r_din_valid <= 1'b1;
                        r_bit_cnt   <= '0;
                        r_grant_id  <= w_grant_idx;
                        r_rr_ptr    <= w_next_ptr;
                    end
                end
                ST_SHIFT: begin
                    if (w_last_bit) begin
                        r_frame_cnt <= r_frame_cnt + CNT_W'(1);
                        r_data_in   <= 1'b0;
                        r_din_valid <= 1'b0;
                        r_gap_cnt   <= '0;
                    end else begin
                        r_data_in <= r_shift[WORD_W-2];
                        r_shift   <= r_shift << 1;
                        r_bit_cnt <= r_bit_cnt + BIT_W'(1);
                    end
                end
                ST_GAP:  r_gap_cnt <= r_gap_cnt + GAP_W'(1);
                default: ;
            endcase
        end
    end

    assign o_data_in   = r_data_in;
    assign o_din_valid = r_din_valid;
    assign o_busy      = (r_state != ST_IDLE);
    assign o_grant_id  = r_grant_id;
    assign o_frame_cnt = r_frame_cnt;
endmodule

// File: doc/vlc_in_sched.md
# vlc_in_sched

Round-robin scheduler that shares the single serial input of the VLC datapath between `N_REQ` parallel-word requesters. It grants one requester at a time and latches its word. The word is shifted MSB-first onto `data_in`/`din_valid`, and a fixed idle gap is enforced between frames. The block sits directly in front of the VLC core, drives its input pins, and reports frame progress as status.

## Interface
- `N_REQ`, 4: number of requesters, ≥2.
- `WORD_W`, 8: bits per frame, ≥2.
- `GAP`, 2: extra idle cycles after each frame, ≥0.
- `CNT_W`, 16: width of the completed-frame counter.

Ports:
- `clk` in 1: single clock; all logic on posedge.
- `rst` in 1: synchronous, active-high reset.
- `enable` in 1: permits new grants; never aborts a frame in progress.
- `req_valid` in N_REQ: per-requester word available.
- `req_data` in N_REQ*WORD_W: requester i word at bits [i*WORD_W +: WORD_W].
- `req_ready` out N_REQ: one-hot acceptance strobe.
- `data_in` out 1: serial bit to the VLC core.
- `din_valid` out 1: `data_in` qualifier.
- `busy` out 1: high in SHIFT or GAP.
- `grant_id` out $clog2(N_REQ): index of the requester currently being serialized.
- `frame_cnt` out CNT_W: count of completed frames, wraps.

## Operation
- The FSM has three states: IDLE, SHIFT, GAP.
- **IDLE:**
  - If `enable` and any `req_valid` is high, pick the first requester i with `req_valid` set, searching from `rr_ptr` upward modulo N_REQ.
  - `req_ready[i]` is high combinationally in this cycle only.
  - At the clock edge: shift register ← `req_data[i]`, `grant_id` ← i, `rr_ptr` ← (i+1) mod N_REQ, bit counter ← 0, state → SHIFT.
- **`req_ready` rules:**
  - It is zero outside IDLE, zero when `enable` is low, and never has more than one bit set.
  - Requesters hold `req_valid` and `req_data` stable until they see `req_ready`.
- **SHIFT:**
  - `data_in` = current MSB and `din_valid` = 1, both registered.
  - Each cycle the register shifts left and the bit counter increments.
  - After bit WORD_W−1 is presented, `frame_cnt` increments modulo 2^CNT_W.
  - State then moves to GAP, or to IDLE when GAP = 0.
- **GAP:** `din_valid` = 0, `data_in` = 0 for GAP cycles, then IDLE.
- `busy` = (state ≠ IDLE). `grant_id` holds its value after a frame until the next grant.
- Dropping `enable` during SHIFT or GAP has no effect on that frame; no new grant follows until `enable` returns high.
- When `din_valid` = 0, `data_in` is always 0.

## Timing
- Reset values:
  - `data_in` = 0, `din_valid` = 0, `busy` = 0, `grant_id` = 0, `frame_cnt` = 0, `req_ready` = 0.
  - Internally: `rr_ptr` = 0, state = IDLE.
- `rst` overrides all other inputs.
- Reset mid-frame: the partial frame is abandoned and `din_valid` is 0 from the next cycle. `frame_cnt` does not count the partial frame, and the shifted word is not re-requested.
- Latency, with the acceptance cycle as cycle 0 (`req_ready` high):
  - First bit is on `data_in` in cycle 1; bits occupy cycles 1..WORD_W.
  - `frame_cnt` shows the new value from cycle WORD_W+1.
  - GAP spans cycles WORD_W+1..WORD_W+GAP.
  - IDLE, and the earliest next `req_ready`, is cycle WORD_W+GAP+1.
- With continuous requests, `din_valid` is low for exactly GAP+1 cycles between frames.
- Frame period is WORD_W+GAP+1 cycles.
- Requests arriving in SHIFT or GAP wait; priority is decided only in the IDLE cycle.
- A requester that drops `req_valid` before being granted is simply skipped.
- Simultaneous requests: the search from `rr_ptr` gives strict round-robin, and each waiting requester is served within N_REQ frames.

## Test plan
- **Single frame (defaults):** requester 0 holds 0xA5, `enable` = 1 → `req_ready` = 0001 for one cycle. `data_in` = 1,0,1,0,0,1,0,1 on cycles 1–8 with `din_valid` high. `din_valid` is low on cycles 9–10, `frame_cnt` = 1, `grant_id` = 0.
- **All four requesters valid** continuously, words 0x11/0x22/0x33/0x44 → grants in order 0,1,2,3,0 with frame starts 11 cycles apart. Each frame serializes its own word, and `din_valid` is low for 3 cycles between frames.
- **Requesters 1 and 3 valid, `rr_ptr` = 2** (after granting 1) → next grant is 3, then 1. `req_ready` is never multi-hot.
- **Reset mid-frame:** `rst` pulses for one cycle during bit 4 → `din_valid`, `busy` and `frame_cnt` read 0 on the next cycle. The next grant goes to requester 0 (`rr_ptr` = 0).
- **`enable` low** from cycle 3 of a frame → the frame completes all 8 bits and `frame_cnt` increments. No `req_ready` appears while `enable` = 0; a grant occurs in the first IDLE cycle after `enable` = 1.
- **GAP = 0, CNT_W = 4,** 17 back-to-back frames → `din_valid` is low for exactly 1 cycle between frames, and `frame_cnt` wraps 15→0→1.
